// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: completes the RCV_REQ/RCV_ACK four-phase handshake and queues received bytes in a show-ahead FIFO.
// Latency: a captured byte is visible on rd_data/rx_empty/irq one cycle after the capture edge; all outputs are registered.
// Backpressure: the receiver is never stalled; a byte arriving while full (and not being read) is dropped and sets overrun.
// Optional build macro RX_TIMEOUT_EN adds an idle timeout (rx_timeout) and batches irq on full/overrun/timeout.
module uart_rx_ctrl #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
`ifdef RX_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 320
`endif
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          RCV_REQ,
  input  logic [7:0]    RCV_Data,
  output logic          RCV_ACK,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          rx_empty,
  output logic          rx_full,
  output logic [AW:0]   rx_count,
  output logic          overrun,
  input  logic          ovr_clr,
  output logic          irq
`ifdef RX_TIMEOUT_EN
  , output logic        rx_timeout
`endif
);

  localparam logic [0:0] IDLE      = 1'b0;
  localparam logic [0:0] WAIT_DROP = 1'b1;

  logic [0:0]    state;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  logic          capture, push, pop, drop;
  logic [AW-1:0] wr_ptr_n, rd_ptr_n;
  logic [AW:0]   count_n, remain;
  logic [7:0]    head_n;
  logic          ovr_n, irq_n;

`ifdef RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_cnt, idle_cnt_n;
  logic          tmo_n;
`endif

  // Datapath next-state: push/pop decisions, occupancy, show-ahead head and flags.
  always_comb begin
    capture  = (state == IDLE) && RCV_REQ;
    pop      = rd_en && !rx_empty;
    // A full FIFO still accepts the byte when the same cycle pops a slot free.
    push     = capture && (!rx_full || rd_en);
    drop     = capture && !push;
    wr_ptr_n = push ? wr_ptr + AW'(1) : wr_ptr;
    rd_ptr_n = pop  ? rd_ptr + AW'(1) : rd_ptr;
    count_n  = rx_count;
    if (push && !pop)      count_n = rx_count + (AW+1)'(1);
    else if (pop && !push) count_n = rx_count - (AW+1)'(1);
    // Entries left once this cycle's pop is taken; zero means the head is the incoming byte.
    remain   = pop ? rx_count - (AW+1)'(1) : rx_count;
    head_n   = 8'h00;
    if (count_n != '0) begin
      if (remain == '0) head_n = RCV_Data;
      else              head_n = mem[rd_ptr_n];
    end
    // Set beats clear so a drop is never lost to a coincident ovr_clr.
    ovr_n = overrun;
    if (ovr_clr) ovr_n = 1'b0;
    if (drop)    ovr_n = 1'b1;
`ifdef RX_TIMEOUT_EN
    idle_cnt_n = idle_cnt;
    tmo_n      = rx_timeout;
    if (push || pop) begin
      idle_cnt_n = '0;
    end else if (!rx_empty) begin
      if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) tmo_n = 1'b1;
      else                                     idle_cnt_n = idle_cnt + TW'(1);
    end
    if (pop || count_n == '0) tmo_n = 1'b0;
    irq_n = (count_n == (AW+1)'(DEPTH)) || ovr_n || tmo_n;
`else
    irq_n = (count_n != '0) || ovr_n;
`endif
  end

  // Handshake FSM: one capture per REQ pulse, ACK follows REQ with one cycle of turnaround.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state   <= IDLE;
      RCV_ACK <= 1'b0;
    end else begin
      case (state)
        IDLE: if (RCV_REQ) begin
          state   <= WAIT_DROP;
          RCV_ACK <= 1'b1;
        end
        WAIT_DROP: if (!RCV_REQ) begin
          state   <= IDLE;
          RCV_ACK <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          RCV_ACK <= 1'b0;
        end
      endcase
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= RCV_Data;
  end

  // Pointers, occupancy, status flags and interrupt.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rx_count <= '0;
      rx_empty <= 1'b1;
      rx_full  <= 1'b0;
      rd_data  <= 8'h00;
      overrun  <= 1'b0;
      irq      <= 1'b0;
`ifdef RX_TIMEOUT_EN
      idle_cnt   <= '0;
      rx_timeout <= 1'b0;
`endif
    end else begin
      wr_ptr   <= wr_ptr_n;
      rd_ptr   <= rd_ptr_n;
      rx_count <= count_n;
      rx_empty <= (count_n == '0);
      rx_full  <= (count_n == (AW+1)'(DEPTH));
      rd_data  <= head_n;
      overrun  <= ovr_n;
      irq      <= irq_n;
`ifdef RX_TIMEOUT_EN
      idle_cnt   <= idle_cnt_n;
      rx_timeout <= tmo_n;
`endif
    end
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Receive-side controller between uart_receiver and the CPU bus. It completes the four-phase RCV_REQ/RCV_ACK handshake with the receiver and queues each received byte in a small FIFO. It presents a show-ahead read port, status flags and an interrupt to the CPU. The receiver is never stalled: a byte arriving while the FIFO is full is dropped and flagged as overrun.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2.
AW, 2, pointer width; equals log2(DEPTH).
TIMEOUT_CYCLES, 320, idle cycles before the timeout event (about 10 bit-times at 32 clk/bit). Used only with RX_TIMEOUT_EN.

Ports:
clk  in  1  system clock; all state changes on its rising edge.
clr  in  1  reset, asynchronous, active-high.
RCV_REQ  in  1  receiver has a byte valid on RCV_Data.
RCV_Data  in  8  received byte; stable while RCV_REQ=1.
RCV_ACK  out  1  handshake acknowledge to the receiver.
rd_en  in  1  CPU pops the head entry.
rd_data  out  8  head entry, show-ahead; 8'h00 when empty.
rx_empty  out  1  FIFO empty.
rx_full  out  1  FIFO holds DEPTH entries.
rx_count  out  AW+1  number of entries held.
overrun  out  1  sticky flag: a byte was dropped.
ovr_clr  in  1  clears overrun.
irq  out  1  level interrupt to the CPU.
rx_timeout  out  1  present only with RX_TIMEOUT_EN.

Behaviour:
- Reset (clr=1, asynchronous): state=IDLE, RCV_ACK=0, pointers=0, rx_count=0, rx_empty=1, rx_full=0, overrun=0, irq=0, rd_data=8'h00, rx_timeout=0.
- Handshake FSM. All outputs are registered.
  - IDLE: on the edge where RCV_REQ=1, capture RCV_Data, set RCV_ACK<=1 and go to WAIT_DROP.
  - The capture pushes into the FIFO if accepted; otherwise it sets overrun<=1 and drops the byte.
  - WAIT_DROP: hold RCV_ACK=1 until a cycle with RCV_REQ=0, then set RCV_ACK<=0 and go to IDLE.
  - Each REQ pulse is captured exactly once; a REQ held high never causes a second push.
  - Minimum turnaround is REQ rise -> ACK rise 1 cycle, and REQ fall -> ACK fall 1 cycle.
- Push acceptance: a push is accepted if rx_full=0, or if rx_full=1 and rd_en=1 in the same cycle (the read frees the slot; count is unchanged).
- Pop: rd_en=1 with rx_empty=1 is ignored. A pop advances the read pointer, and rd_data shows the next entry in the following cycle.
- Push and pop in the same cycle when non-empty: both occur and rx_count is unchanged.
- Push to an empty FIFO: rx_empty drops, and rd_data is valid 1 cycle after the capture edge.
- Pointers are AW bits and wrap modulo DEPTH. rx_count is AW+1 bits and never exceeds DEPTH.
- overrun: set on a dropped byte, cleared by ovr_clr. If set and ovr_clr occur in the same cycle, set wins.
- irq = registered (!rx_empty | overrun).
- clr asserted mid-handshake returns the FSM to IDLE with ACK=0. If RCV_REQ is still high after clr releases, that byte is captured again. This is accepted behaviour.

Optional Feature:
Macro RX_TIMEOUT_EN.
- Defined:
  - An idle counter increments each cycle while rx_empty=0 and resets to 0 on any push or pop.
  - When it reaches TIMEOUT_CYCLES-1, rx_timeout<=1 (sticky) and the counter holds.
  - rx_timeout clears on a pop or when the FIFO goes empty.
  - irq = registered (rx_full | overrun | rx_timeout), i.e. it batches interrupts.
- Undefined: no counter and no rx_timeout port; irq is as in Behaviour.

Test Plan:
- Reset: hold clr=1 with RCV_REQ=1 -> RCV_ACK=0, rx_empty=1, irq=0. Release clr -> ACK rises 1 cycle later and 8'h54 is queued.
- Single byte: REQ with Data=8'h54, REQ held 20 cycles -> exactly one entry, ACK high until 1 cycle after REQ falls, rd_data=8'h54, irq=1. Pop -> rx_empty=1, irq=0.
- Order and wrap: push 8'h54, 8'h5A, 8'h41, 8'h42, pop 2, push 8'h43, 8'h44 -> pops return 41,42,43,44 and the pointers have wrapped.
- Overrun: fill with 4 bytes, then REQ with Data=8'hFF -> handshake still completes, byte dropped, overrun=1, FIFO contents unchanged. ovr_clr -> overrun=0.
- Simultaneous events: FIFO full plus REQ capture edge with rd_en=1 -> no overrun, rx_count stays 4, new byte at tail. Also ovr_clr coincident with a drop -> overrun stays 1.
- RX_TIMEOUT_EN: one byte pushed, no pops -> rx_timeout and irq assert exactly TIMEOUT_CYCLES cycles after the push. Pop -> both clear.
